// File: rtl/nixie_scan_controller.sv
// Scans NUM_DIGITS BCD digits onto one shared decoder with per-digit anode selects.
// A double-buffered load port swaps in new values only at frame boundaries.
//
// state | meaning
// BLANK | decoder disabled, no anode; dec_bcd pre-settles to the next digit
// DRIVE | anode of current digit on, decoder enabled when the digit is shown
module nixie_scan_controller #(
   parameter int NUM_DIGITS = 4,
   parameter int DWELL_CYC  = 8,
   parameter int BLANK_CYC  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   input  logic                    lz_blank,
   output logic                    dec_enable,
   output logic [3:0]              dec_bcd,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    frame_done
);

   localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int MAXC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_DRIVE = 1'b1;

   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0] BLANK_TC = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0] DWELL_TC = CW'(DWELL_CYC - 1);

   logic [0:0]              state, state_nxt;
   logic [IW-1:0]           idx, idx_nxt;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [4*NUM_DIGITS-1:0] active, active_nxt, shadow;
   logic                    pending;
   logic                    boundary;
   logic                    accept;
   logic [3:0]              nib_nxt;
   logic                    zeros_up;
   logic                    show_nxt;

   assign load_ready = ~pending;
   assign accept     = load_valid & ~pending;
   assign boundary   = (state == ST_DRIVE) && (cnt == DWELL_TC) && (idx == LAST_IDX);
   assign active_nxt = (boundary && pending) ? shadow : active;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt + 1'b1;
      case (state)
         ST_BLANK: begin
            if (cnt == BLANK_TC) begin
               state_nxt = ST_DRIVE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            if (cnt == DWELL_TC) begin
               state_nxt = ST_BLANK;
               cnt_nxt   = '0;
               idx_nxt   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
         end
      endcase
   end

   // Outputs are computed from the state being entered, so they settle on the same edge.
   always_comb begin
      nib_nxt  = active_nxt[4*idx_nxt +: 4];
      zeros_up = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if ((i >= int'(idx_nxt)) && (active_nxt[4*i +: 4] != 4'd0)) begin
            zeros_up = 1'b0;
         end
      end
      show_nxt = (nib_nxt <= 4'd9) && !(lz_blank && (idx_nxt != '0) && zeros_up);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_BLANK;
         idx        <= '0;
         cnt        <= '0;
         active     <= '0;
         shadow     <= '0;
         pending    <= 1'b0;
         dec_enable <= 1'b0;
         dec_bcd    <= 4'd0;
         digit_sel  <= '0;
         frame_done <= 1'b0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         cnt    <= cnt_nxt;
         active <= active_nxt;
         if (boundary && pending) begin
            pending <= 1'b0;
         end else if (accept) begin
            shadow  <= load_data;
            pending <= 1'b1;
         end
         dec_bcd    <= nib_nxt;
         digit_sel  <= (state_nxt == ST_DRIVE) ? (NUM_DIGITS'(1) << idx_nxt) : '0;
         dec_enable <= (state_nxt == ST_DRIVE) && show_nxt;
         frame_done <= (state_nxt == ST_DRIVE) && (idx_nxt == LAST_IDX) && (cnt_nxt == DWELL_TC);
      end
   end

endmodule

// File: tb/tb_nixie_scan_controller.sv
// Directed bench for nixie_scan_controller at default parameters (4 digits, 40-cycle frame).
module tb_nixie_scan_controller;

   logic        clk;
   logic        rst_n;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_data;
   logic        lz_blank;
   logic        dec_enable;
   logic [3:0]  dec_bcd;
   logic [3:0]  digit_sel;
   logic        frame_done;

   nixie_scan_controller #(
      .NUM_DIGITS(4),
      .DWELL_CYC (8),
      .BLANK_CYC (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .load_data (load_data),
      .lz_blank  (lz_blank),
      .dec_enable(dec_enable),
      .dec_bcd   (dec_bcd),
      .digit_sel (digit_sel),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] word;
      logic        lz;
      logic [3:0]  en;
   } vec_t;

   vec_t        vecs[10];
   int          checks = 0;
   int          errors = 0;
   logic        exp_pend;
   logic        prod_valid;
   logic [15:0] prod_word;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d actual %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Runs ncyc cycles from the start of a frame. Display is checked against exp_word/exp_en
   // when chk is set; load_ready and frame_done are always checked. The producer holds
   // load_valid from cycle la1 (word w1) or la2 (word w2) until the load is accepted.
   task automatic run_frame(input logic [15:0] exp_word, input logic [3:0] exp_en, input bit chk,
                            input int la1, input logic [15:0] w1,
                            input int la2, input logic [15:0] w2, input int ncyc);
      int          d;
      int          ph;
      logic [3:0]  e_sel;
      logic        e_en;
      logic [3:0]  e_bcd;
      logic        acc;
      for (int c = 0; c < ncyc; c++) begin
         d     = c / 10;
         ph    = c % 10;
         e_sel = (ph < 2) ? 4'b0000 : (4'b0001 << d);
         e_en  = (ph >= 2) && exp_en[d];
         e_bcd = exp_word[4*d +: 4];
         if (chk) check("display", c, {23'd0, digit_sel, e_en ^ e_en ^ dec_enable, dec_bcd},
                        {23'd0, e_sel, e_en, e_bcd});
         check("frame_done", c, {31'd0, frame_done}, {31'd0, (c == 39)});
         check("load_ready", c, {31'd0, load_ready}, {31'd0, ~exp_pend});
         if (c == la1) begin
            prod_valid = 1'b1;
            prod_word  = w1;
         end
         if (c == la2) begin
            prod_valid = 1'b1;
            prod_word  = w2;
         end
         load_valid = prod_valid;
         load_data  = prod_valid ? prod_word : 16'($urandom);
         acc        = prod_valid && !exp_pend;
         if ((c == 39) && exp_pend) exp_pend = 1'b0;
         else if (acc)              exp_pend = 1'b1;
         if (acc) prod_valid = 1'b0;
         tick();
         load_valid = 1'b0;
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, 0, {22'd0, digit_sel, dec_enable, dec_bcd, frame_done, load_ready},
            {22'd0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b1});
   endtask

   initial begin
      vecs[0] = '{16'h0007, 1'b1, 4'b0001};
      vecs[1] = '{16'h0000, 1'b1, 4'b0001};
      vecs[2] = '{16'h0100, 1'b1, 4'b0111};
      vecs[3] = '{16'h9A05, 1'b0, 4'b1011};
      vecs[4] = '{16'h9A05, 1'b1, 4'b1011};
      vecs[5] = '{16'h1234, 1'b1, 4'b1111};
      vecs[6] = '{16'h0090, 1'b1, 4'b0011};
      vecs[7] = '{16'hF000, 1'b1, 4'b0111};
      vecs[8] = '{16'h00C0, 1'b1, 4'b0001};
      vecs[9] = '{16'h0000, 1'b0, 4'b1111};

      rst_n      = 1'b1;
      load_valid = 1'b0;
      load_data  = 16'd0;
      lz_blank   = 1'b0;
      exp_pend   = 1'b0;
      prod_valid = 1'b0;
      prod_word  = 16'd0;
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset_async");
      tick();
      tick();
      check_reset_outputs("reset_held");
      rst_n = 1'b1;

      // Power-up frame of zeros, then 0x1234 accepted in cycle 5 appears in frame 2.
      run_frame(16'h0000, 4'b1111, 1'b1, 5, 16'h1234, -1, 16'h0, 40);
      run_frame(16'h1234, 4'b1111, 1'b1, -1, 16'h0, -1, 16'h0, 40);

      foreach (vecs[k]) begin
         lz_blank = vecs[k].lz;
         run_frame(16'h0000, 4'b0000, 1'b0, 0, vecs[k].word, -1, 16'h0, 40);
         run_frame(vecs[k].word, vecs[k].en, 1'b1, -1, 16'h0, -1, 16'h0, 40);
      end
      lz_blank = 1'b0;

      // Back-to-back: 0x2222 stalls behind 0x1111 until the boundary frees the shadow.
      run_frame(16'h0000, 4'b0000, 1'b0, 3, 16'h1111, 4, 16'h2222, 40);
      run_frame(16'h1111, 4'b1111, 1'b1, -1, 16'h0, -1, 16'h0, 40);
      // Load in the boundary cycle itself is held back one frame.
      run_frame(16'h2222, 4'b1111, 1'b1, 39, 16'h3333, -1, 16'h0, 40);
      run_frame(16'h2222, 4'b1111, 1'b1, -1, 16'h0, -1, 16'h0, 40);
      run_frame(16'h3333, 4'b1111, 1'b1, 0, 16'h5678, -1, 16'h0, 40);

      // Reset during digit 2 DRIVE with 0x9999 pending.
      run_frame(16'h5678, 4'b1111, 1'b1, 10, 16'h9999, -1, 16'h0, 25);
      check("pre_reset_drive", 25, {23'd0, digit_sel, dec_enable, dec_bcd}, {23'd0, 4'b0100, 1'b1, 4'd6});
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("reset_midrun");
      tick();
      tick();
      tick();
      check_reset_outputs("reset_midrun_held");
      rst_n      = 1'b1;
      exp_pend   = 1'b0;
      prod_valid = 1'b0;
      run_frame(16'h0000, 4'b1111, 1'b1, -1, 16'h0, -1, 16'h0, 40);
      run_frame(16'h0000, 4'b1111, 1'b1, -1, 16'h0, -1, 16'h0, 40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nixie_scan_controller.md
Name: nixie_scan_controller

Overview:
- Time-multiplexes NUM_DIGITS BCD digits onto one shared BCD-to-decimal decoder plus per-digit anode selects. Built for nixie or lamp-column displays.
- Takes a packed digit word through a valid/ready load port and double-buffers it so the display only changes at frame boundaries.
- For each digit, inserts a blanking gap (decoder disabled, no anode) before the drive window, to prevent ghosting.
- Sits between the value-producing logic and the decoder/anode drivers.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal 2..16; digit 0 is least significant.
- DWELL_CYC, 8, cycles each digit is driven; legal >=1.
- BLANK_CYC, 2, blanking cycles before each digit's drive window; legal >=1.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  controller can accept a load.
- load_data  input  4*NUM_DIGITS  packed BCD digits; nibble i (bits 4i+3:4i) is digit i.
- lz_blank  input  1  enables leading-zero blanking.
- dec_enable  output  1  enable to the shared decoder.
- dec_bcd  output  4  BCD code to the shared decoder.
- digit_sel  output  NUM_DIGITS  one-hot anode select; all-zero while blanking.
- frame_done  output  1  one-cycle pulse on the last drive cycle of the last digit.

Behaviour:
- Reset (async assert, sync release). Values while reset is asserted:
  - state=BLANK, digit index=0, phase counter=0.
  - active=0, shadow=0, pending=0.
  - dec_enable=0, dec_bcd=0, digit_sel=0, frame_done=0, load_ready=1.
- All outputs except load_ready are registered. They take the value of the state entered on each edge. load_ready = ~pending (combinational from a flop).
- FSM:
  - BLANK: lasts BLANK_CYC cycles.
    - digit_sel=0, dec_enable=0.
    - dec_bcd = active nibble of the current index (pre-settles the decoder input).
    - When the counter reaches BLANK_CYC-1: go to DRIVE, counter=0.
  - DRIVE: lasts DWELL_CYC cycles.
    - digit_sel = one-hot(index).
    - dec_bcd = active nibble; dec_enable = show(index).
    - When the counter reaches DWELL_CYC-1: go to BLANK, counter=0, index = index+1, wrapping NUM_DIGITS-1 to 0.
- Frame length is NUM_DIGITS*(BLANK_CYC+DWELL_CYC) cycles; 40 with defaults.
- show(i) = 1 only if both hold:
  - nibble i <= 9. Codes 10-15 are blanked; digit_sel still asserts and dec_bcd still carries the raw code.
  - NOT(lz_blank=1 AND i != 0 AND nibbles i..NUM_DIGITS-1 are all zero).
  - Digit 0 is never leading-zero blanked.
- lz_blank is sampled every cycle; a change takes effect at the next DRIVE output update.
- Load handshake:
  - Accept when load_valid & load_ready: shadow <= load_data, pending <= 1.
  - load_data is ignored when not accepted.
- Frame boundary is the edge leaving the last DRIVE cycle of digit NUM_DIGITS-1. At that edge:
  - If pending=1 (pre-edge value): active <= shadow, pending <= 0.
  - If pending=0: active is unchanged.
  - Digit 0's BLANK of the new frame already shows the new value.
- Simultaneous accept and boundary (pending=0 pre-edge): data goes to shadow only and pending=1. It is displayed from the following frame.
- While pending=1, load_ready=0 and the producer must hold.
- frame_done is high exactly during the final DRIVE cycle of digit NUM_DIGITS-1, once per frame.
- Reset mid-operation: all outputs drop immediately and pending data is discarded. The scan restarts at BLANK of digit 0 on the first edge after release.

Test Plan:
- Reset release, no load, lz_blank=0, defaults.
  - Cycles 0-1: digit_sel=0, dec_enable=0.
  - Cycles 2-9: digit_sel=0001, dec_bcd=0, dec_enable=1.
  - Pattern repeats for digits 1-3. frame_done high at cycle 39 only.
- Load 0x1234 accepted in cycle 5.
  - load_ready=0 from cycle 6 until the boundary edge after cycle 39.
  - Frame 2 shows digit0=4, digit1=3, digit2=2, digit3=1, each over 8 drive cycles.
- Load 0x0007 with lz_blank=1.
  - Digit 0: dec_bcd=7, dec_enable=1.
  - Digits 1-3: digit_sel one-hot but dec_enable=0.
  - Load 0x0000: only digit 0 enabled, showing 0.
  - Load 0x0100: digits 0, 1, 2 enabled; digit 3 blanked.
- Load 0x9A05.
  - Digit 2 slot: dec_bcd=1010, digit_sel=0100, dec_enable=0.
  - Digit 3 shows 9. Digits 0 and 1 show 5 and 0, both enabled with lz_blank=0.
- Back-to-back loads 0x1111 then 0x2222.
  - 0x2222 stalls (load_ready=0) until 0x1111 transfers.
  - 0x1111 displays one full frame, then 0x2222 the next.
  - load_valid asserted exactly in the boundary cycle with pending=0: display is delayed one frame.
- rst_n low for 3 cycles during digit 2 DRIVE, after loading 0x5678.
  - Outputs are 0 within the same cycle.
  - After release: BLANK of digit 0, then display of 0000 (loaded value lost), load_ready=1.
